// File: rtl/two_comp_add.sv
// two_comp_add: parameterised two's-complement adder/subtractor.
//
// c_in selects the operation (0: x + y, 1: x - y). Subtraction is done as
// x + ~y + 1 by inverting y and reusing c_in as the carry-in.
//
// Ports:
//   clk       rising-edge clock for the registered stage
//   rst_n     asynchronous active-low reset (registered stage only)
//   x, y      WIDTH-bit two's-complement operands
//   c_in      mode / carry-in: 0 = add, 1 = subtract
//   in_valid  capture the current result into the output register
//   sum       combinational result (modulo 2^WIDTH)
//   c_out     combinational carry out of the MSB (subtract: 1 = no borrow)
//   sum_q     registered result
//   c_out_q   registered carry out
//   ovf_q     registered signed overflow
//   zero_q    registered sum_q == 0 flag (meaningful only with out_valid)
//   neg_q     registered sign bit of sum_q
//   out_valid registered outputs hold a fresh result this cycle
module two_comp_add #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [WIDTH-1:0] sum_q,
    output logic             c_out_q,
    output logic             ovf_q,
    output logic             zero_q,
    output logic             neg_q,
    output logic             out_valid
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] t;
    logic [WIDTH:0]   full;
    logic             ovf;

    always_comb begin
        t    = y ^ {WIDTH{c_in}};
        // Extend to WIDTH+1 bits so the carry out of the MSB is kept.
        full = {1'b0, x} + {1'b0, t} + {{WIDTH{1'b0}}, c_in};
        sum  = full[WIDTH-1:0];
        c_out = full[WIDTH];
        // Overflow: operands share a sign and the result's sign differs.
        ovf  = (x[MSB] == t[MSB]) && (sum[MSB] != x[MSB]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            c_out_q   <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q   <= sum;
                c_out_q <= c_out;
                ovf_q   <= ovf;
                zero_q  <= (sum == '0);
                neg_q   <= sum[MSB];
            end
        end
    end

endmodule

// File: tb/tb_two_comp_add.sv
// tb_two_comp_add: self-checking bench for two_comp_add (WIDTH = 4).
// Expected results come from an integer model and are queued when an
// operation is launched, then popped when the registered stage reports it.
module tb_two_comp_add;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         z;
        logic         n;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c_in;
    logic         in_valid;
    logic [W-1:0] sum;
    logic         c_out;
    logic [W-1:0] sum_q;
    logic         c_out_q;
    logic         ovf_q;
    logic         zero_q;
    logic         neg_q;
    logic         out_valid;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    two_comp_add #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .y        (y),
        .c_in     (c_in),
        .in_valid (in_valid),
        .sum      (sum),
        .c_out    (c_out),
        .sum_q    (sum_q),
        .c_out_q  (c_out_q),
        .ovf_q    (ovf_q),
        .zero_q   (zero_q),
        .neg_q    (neg_q),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer reference: unsigned arithmetic for carry, signed for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub);
        exp_t e;
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = a[W-1] ? ua - (1 << W) : ua;
        sb = b[W-1] ? ub - (1 << W) : ub;
        if (!sub) begin
            ur  = ua + ub;
            sr  = sa + sb;
            e.c = (ur >= (1 << W));
        end else begin
            ur  = ua - ub + (1 << W);
            sr  = sa - sb;
            e.c = (ua >= ub);
        end
        e.s = ur[W-1:0];
        e.o = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        e.z = (e.s == '0);
        e.n = e.s[W-1];
        return e;
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        x        = '0;
        y        = '0;
        c_in     = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sum_q, c_out_q, ovf_q, zero_q, neg_q, out_valid} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got %b want 0",
                     {sum_q, c_out_q, ovf_q, zero_q, neg_q, out_valid});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid: got %b want 0", out_valid);
        end
    endtask

    // Directed vectors run back to back: each cycle launches one operation
    // and checks the registered result of the previous one.
    task automatic test_vectors();
        logic [W*2:0] vec [6];
        exp_t         e;
        vec[0] = {4'b1100, 4'b1010, 1'b0};
        vec[1] = {4'b0101, 4'b1110, 1'b0};
        vec[2] = {4'b0101, 4'b0011, 1'b1};
        vec[3] = {4'b0011, 4'b0101, 1'b1};
        vec[4] = {4'b0111, 4'b1000, 1'b1};
        vec[5] = {4'b0110, 4'b0110, 1'b1};
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL vec_queue_empty: step %0d", i);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if ({out_valid, sum_q, c_out_q, ovf_q, zero_q, neg_q} !==
                        {1'b1, e.s, e.c, e.o, e.z, e.n}) begin
                        errors++;
                        $display("FAIL vec_reg[%0d]: got v=%b s=%b c=%b o=%b z=%b n=%b want v=1 s=%b c=%b o=%b z=%b n=%b",
                                 i - 1, out_valid, sum_q, c_out_q, ovf_q, zero_q, neg_q,
                                 e.s, e.c, e.o, e.z, e.n);
                    end
                end
            end
            if (i < 6) begin
                {x, y, c_in} = vec[i];
                in_valid     = 1'b1;
                #1;
                e = model(x, y, c_in);
                checks++;
                if ({c_out, sum} !== {e.c, e.s}) begin
                    errors++;
                    $display("FAIL vec_comb[%0d]: got c=%b s=%b want c=%b s=%b",
                             i, c_out, sum, e.c, e.s);
                end
                sb_q.push_back(e);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_valid_pulse();
        exp_t        e;
        logic [W-1:0] held;
        @(negedge clk);
        x = 4'b1001; y = 4'b0100; c_in = 1'b0; in_valid = 1'b1;
        #1;
        e = model(x, y, c_in);
        held = e.s;
        @(negedge clk);
        in_valid = 1'b0;
        x = 4'b0001; y = 4'b0001;
        checks++;
        if (out_valid !== 1'b1 || sum_q !== held) begin
            errors++;
            $display("FAIL pulse_capture: got v=%b s=%b want v=1 s=%b", out_valid, sum_q, held);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || sum_q !== held) begin
                errors++;
                $display("FAIL pulse_hold[%0d]: got v=%b s=%b want v=0 s=%b",
                         k, out_valid, sum_q, held);
            end
        end
    endtask

    // Random back-to-back traffic with in_valid gaps.
    task automatic test_back_to_back();
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (prev_v) begin
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_queue_empty: step %0d", i);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if ({out_valid, sum_q, c_out_q, ovf_q, zero_q, neg_q} !==
                        {1'b1, e.s, e.c, e.o, e.z, e.n}) begin
                        errors++;
                        $display("FAIL b2b_reg[%0d]: got v=%b s=%b c=%b o=%b z=%b n=%b want s=%b c=%b o=%b z=%b n=%b",
                                 i, out_valid, sum_q, c_out_q, ovf_q, zero_q, neg_q,
                                 e.s, e.c, e.o, e.z, e.n);
                    end
                end
            end else if (i > 0) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle[%0d]: got v=%b want 0", i, out_valid);
                end
            end
            if (i < 40) begin
                x        = W'($urandom_range(0, (1 << W) - 1));
                y        = W'($urandom_range(0, (1 << W) - 1));
                c_in     = 1'($urandom_range(0, 1));
                in_valid = ($urandom_range(0, 3) != 0);
                #1;
                e = model(x, y, c_in);
                checks++;
                if ({c_out, sum} !== {e.c, e.s}) begin
                    errors++;
                    $display("FAIL b2b_comb[%0d]: got c=%b s=%b want c=%b s=%b",
                             i, c_out, sum, e.c, e.s);
                end
                if (in_valid) sb_q.push_back(e);
                prev_v = in_valid;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        // Load a non-zero result so a cleared register is observable.
        @(negedge clk);
        x = 4'b0011; y = 4'b0101; c_in = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        // Second capture pending when reset hits between edges.
        x = 4'b0111; y = 4'b1000;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sum_q, c_out_q, ovf_q, zero_q, neg_q, out_valid} !== '0) begin
            errors++;
            $display("FAIL async_reset_regs: got %b want 0",
                     {sum_q, c_out_q, ovf_q, zero_q, neg_q, out_valid});
        end
        x = 4'b0010; y = 4'b0011; c_in = 1'b0;
        #1;
        e = model(x, y, c_in);
        checks++;
        if ({c_out, sum} !== {e.c, e.s}) begin
            errors++;
            $display("FAIL async_reset_comb: got c=%b s=%b want c=%b s=%b", c_out, sum, e.c, e.s);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sum_q !== '0) begin
            errors++;
            $display("FAIL async_reset_lost: got v=%b s=%b want v=0 s=0", out_valid, sum_q);
        end
        sb_q.delete();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_valid_pulse();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached want finish");
        $fatal(1, "timeout");
    end

endmodule
